ps2_scancode_decoder: RTL and testbench

//  Downstream of the PS/2 frame receiver. Takes completed scan-code bytes plus a 1-cycle valid strobe.

---
 rtl/ps2_scancode_decoder_if.sv | 37 +++
 rtl/ps2_scancode_decoder.sv | 180 ++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_decoder_if.sv
// Bus between the PS/2 frame receiver, the scan-code decoder and the
// display/debug logic that consumes key events.
//   code_valid/code            : received byte strobe and value (into decoder)
//   evt_*                      : registered key event fields, evt_valid pulses
//   key_down/held_code/held_ext: currently held key
//   press_cnt                  : non-repeat make events since reset (wraps)
//   err                        : one-cycle protocol error pulse
// master = byte producer / event consumer, slave = decoder.
interface ps2_scancode_decoder_if #(
    parameter int unsigned CNT_W = 8
);
    logic             code_valid;
    logic [7:0]       code;
    logic             evt_valid;
    logic [7:0]       evt_code;
    logic             evt_ext;
    logic             evt_release;
    logic             evt_repeat;
    logic [7:0]       evt_ascii;
    logic             key_down;
    logic [7:0]       held_code;
    logic             held_ext;
    logic [CNT_W-1:0] press_cnt;
    logic             err;

    modport master (
        output code_valid, code,
        input  evt_valid, evt_code, evt_ext, evt_release, evt_repeat, evt_ascii,
        input  key_down, held_code, held_ext, press_cnt, err
    );

    modport slave (
        input  code_valid, code,
        output evt_valid, evt_code, evt_ext, evt_release, evt_repeat, evt_ascii,
        output key_down, held_code, held_ext, press_cnt, err
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder. Parses make / F0 break / E0 extended sequences
// into registered key events, tracks the held key, flags typematic repeats,
// counts presses and maps codes to uppercase ASCII.
// Ports:
//   clk    : system clock, posedge
//   resetn : synchronous reset, active low
//   bus    : ps2_scancode_decoder_if.slave (byte input, event/status outputs)
module ps2_scancode_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    ps2_scancode_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

    state_e state_q, state_d;

    logic             is_make, is_break, is_err, ev_ext;
    logic             is_e0, is_f0, is_bad, held_match;

    logic             evt_valid_q,   evt_valid_d;
    logic [7:0]       evt_code_q,    evt_code_d;
    logic             evt_ext_q,     evt_ext_d;
    logic             evt_release_q, evt_release_d;
    logic             evt_repeat_q,  evt_repeat_d;
    logic [7:0]       evt_ascii_q,   evt_ascii_d;
    logic             key_down_q,    key_down_d;
    logic [7:0]       held_code_q,   held_code_d;
    logic             held_ext_q,    held_ext_d;
    logic [CNT_W-1:0] press_cnt_q,   press_cnt_d;
    logic             err_q,         err_d;

    function automatic logic [7:0] to_ascii(input logic [7:0] c);
        case (c)
            8'h1C: to_ascii = 8'h41; 8'h32: to_ascii = 8'h42; 8'h21: to_ascii = 8'h43;
            8'h23: to_ascii = 8'h44; 8'h24: to_ascii = 8'h45; 8'h2B: to_ascii = 8'h46;
            8'h34: to_ascii = 8'h47; 8'h33: to_ascii = 8'h48; 8'h43: to_ascii = 8'h49;
            8'h3B: to_ascii = 8'h4A; 8'h42: to_ascii = 8'h4B; 8'h4B: to_ascii = 8'h4C;
            8'h3A: to_ascii = 8'h4D; 8'h31: to_ascii = 8'h4E; 8'h44: to_ascii = 8'h4F;
            8'h4D: to_ascii = 8'h50; 8'h15: to_ascii = 8'h51; 8'h2D: to_ascii = 8'h52;
            8'h1B: to_ascii = 8'h53; 8'h2C: to_ascii = 8'h54; 8'h3C: to_ascii = 8'h55;
            8'h2A: to_ascii = 8'h56; 8'h1D: to_ascii = 8'h57; 8'h22: to_ascii = 8'h58;
            8'h35: to_ascii = 8'h59; 8'h1A: to_ascii = 8'h5A;
            8'h45: to_ascii = 8'h30; 8'h16: to_ascii = 8'h31; 8'h1E: to_ascii = 8'h32;
            8'h26: to_ascii = 8'h33; 8'h25: to_ascii = 8'h34; 8'h2E: to_ascii = 8'h35;
            8'h36: to_ascii = 8'h36; 8'h3D: to_ascii = 8'h37; 8'h3E: to_ascii = 8'h38;
            8'h46: to_ascii = 8'h39;
            8'h29: to_ascii = 8'h20; 8'h5A: to_ascii = 8'h0D; 8'h66: to_ascii = 8'h08;
            default: to_ascii = 8'h00;
        endcase
    endfunction

    assign is_e0  = (bus.code == 8'hE0);
    assign is_f0  = (bus.code == 8'hF0);
    assign is_bad = (bus.code == 8'h00) || (bus.code == 8'hFF);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.code_valid) begin
            case (state_q)
                IDLE:    state_d = is_e0 ? EXT : (is_f0 ? BRK : IDLE);
                EXT:     state_d = is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
                BRK:     state_d = is_f0 ? BRK : (is_e0 ? EXT : IDLE);
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode: classify the byte sampled this cycle
    always_comb begin
        is_make  = 1'b0;
        is_break = 1'b0;
        is_err   = 1'b0;
        ev_ext   = 1'b0;
        if (bus.code_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_bad)                is_err  = 1'b1;
                    else if (!is_e0 && !is_f0) is_make = 1'b1;
                end
                EXT: begin
                    ev_ext = 1'b1;
                    if (is_bad)                is_err  = 1'b1;
                    else if (!is_e0 && !is_f0) is_make = 1'b1;
                end
                BRK: begin
                    if (is_bad || is_e0) is_err   = 1'b1;
                    else if (!is_f0)     is_break = 1'b1;
                end
                EXT_BRK: begin
                    ev_ext = 1'b1;
                    if (is_bad || is_e0 || is_f0) is_err   = 1'b1;
                    else                          is_break = 1'b1;
                end
                default: is_err = 1'b0;
            endcase
        end
    end

    assign held_match = key_down_q && (held_ext_q == ev_ext) && (held_code_q == bus.code);

    // Event fields and held-key tracking
    always_comb begin
        evt_valid_d   = is_make | is_break;
        err_d         = is_err;
        evt_code_d    = evt_code_q;
        evt_ext_d     = evt_ext_q;
        evt_release_d = evt_release_q;
        evt_repeat_d  = evt_repeat_q;
        evt_ascii_d   = evt_ascii_q;
        key_down_d    = key_down_q;
        held_code_d   = held_code_q;
        held_ext_d    = held_ext_q;
        press_cnt_d   = press_cnt_q;
        if (is_make || is_break) begin
            evt_code_d    = bus.code;
            evt_ext_d     = ev_ext;
            evt_release_d = is_break;
            evt_repeat_d  = is_make && held_match;
            evt_ascii_d   = ev_ext ? 8'h00 : to_ascii(bus.code);
        end
        if (is_make && !held_match) begin
            press_cnt_d = press_cnt_q + 1'b1;
            held_code_d = bus.code;
            held_ext_d  = ev_ext;
            key_down_d  = 1'b1;
        end
        // A break for some other key is reported but leaves the held key alone
        if (is_break && held_match) key_down_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            evt_valid_q   <= 1'b0;
            evt_code_q    <= '0;
            evt_ext_q     <= 1'b0;
            evt_release_q <= 1'b0;
            evt_repeat_q  <= 1'b0;
            evt_ascii_q   <= '0;
            key_down_q    <= 1'b0;
            held_code_q   <= '0;
            held_ext_q    <= 1'b0;
            press_cnt_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            evt_valid_q   <= evt_valid_d;
            evt_code_q    <= evt_code_d;
            evt_ext_q     <= evt_ext_d;
            evt_release_q <= evt_release_d;
            evt_repeat_q  <= evt_repeat_d;
            evt_ascii_q   <= evt_ascii_d;
            key_down_q    <= key_down_d;
            held_code_q   <= held_code_d;
            held_ext_q    <= held_ext_d;
            press_cnt_q   <= press_cnt_d;
            err_q         <= err_d;
        end
    end

    assign bus.evt_valid   = evt_valid_q;
    assign bus.evt_code    = evt_code_q;
    assign bus.evt_ext     = evt_ext_q;
    assign bus.evt_release = evt_release_q;
    assign bus.evt_repeat  = evt_repeat_q;
    assign bus.evt_ascii   = evt_ascii_q;
    assign bus.key_down    = key_down_q;
    assign bus.held_code   = held_code_q;
    assign bus.held_ext    = held_ext_q;
    assign bus.press_cnt   = press_cnt_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed byte sequences, a byte-level
// reference model compared against every output each cycle, plus literal
// expectations at key points of each scenario.
module tb_ps2_scancode_decoder;
    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    ps2_scancode_decoder_if #(.CNT_W(8)) bus ();

    ps2_scancode_decoder #(.CNT_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- reference model ----------------
    bit       p_ext, p_brk;          // prefixes seen so far in the current sequence
    bit       m_valid, m_err, m_ext, m_rel, m_rep, m_kd, m_hext;
    byte unsigned m_code, m_ascii, m_hcode;
    int       m_cnt;

    byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};

    function automatic byte unsigned ascii_of(input byte unsigned c);
        for (int i = 0; i < 26; i++) if (letter_codes[i] == c) return 8'(65 + i);
        for (int i = 0; i < 10; i++) if (digit_codes[i] == c) return 8'(48 + i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            p_ext = 0; p_brk = 0; m_valid = 0; m_err = 0; m_ext = 0; m_rel = 0;
            m_rep = 0; m_kd = 0; m_hext = 0; m_code = 0; m_ascii = 0; m_hcode = 0; m_cnt = 0;
        end else begin
            m_valid = 0;
            m_err   = 0;
            if (bus.code_valid) begin
                byte unsigned c;
                c = bus.code;
                if (c == 8'h00 || c == 8'hFF) begin
                    m_err = 1; p_ext = 0; p_brk = 0;
                end else if (c == 8'hE0) begin
                    // E0 after F0: error; a lone F0 becomes an E0 prefix, E0 F0 is dropped
                    if (p_brk) begin m_err = 1; p_ext = !p_ext; p_brk = 0; end
                    else p_ext = 1;
                end else if (c == 8'hF0) begin
                    if (p_ext && p_brk) begin m_err = 1; p_ext = 0; p_brk = 0; end
                    else p_brk = 1;
                end else begin
                    bit same;
                    same    = m_kd && (m_hext == p_ext) && (m_hcode == c);
                    m_valid = 1;
                    m_code  = c;
                    m_ext   = p_ext;
                    m_rel   = p_brk;
                    m_ascii = p_ext ? 8'h00 : ascii_of(c);
                    if (!p_brk) begin
                        m_rep = same;
                        if (!same) begin
                            m_cnt = (m_cnt + 1) % 256;
                            m_hcode = c; m_hext = p_ext; m_kd = 1;
                        end
                    end else begin
                        m_rep = 0;
                        if (same) m_kd = 0;
                    end
                    p_ext = 0; p_brk = 0;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("evt_valid",   32'(bus.evt_valid),   32'(m_valid));
            cmp("evt_code",    32'(bus.evt_code),    32'(m_code));
            cmp("evt_ext",     32'(bus.evt_ext),     32'(m_ext));
            cmp("evt_release", 32'(bus.evt_release), 32'(m_rel));
            cmp("evt_repeat",  32'(bus.evt_repeat),  32'(m_rep));
            cmp("evt_ascii",   32'(bus.evt_ascii),   32'(m_ascii));
            cmp("key_down",    32'(bus.key_down),    32'(m_kd));
            cmp("held_code",   32'(bus.held_code),   32'(m_hcode));
            cmp("held_ext",    32'(bus.held_ext),    32'(m_hext));
            cmp("press_cnt",   32'(bus.press_cnt),   32'(m_cnt));
            cmp("err",         32'(bus.err),         32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the next negedge with the byte's result visible.
    task automatic send(input byte unsigned b);
        bus.code_valid = 1'b1;
        bus.code       = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        cmp("rst evt_valid", 32'(bus.evt_valid), 32'd0);
        cmp("rst press_cnt", 32'(bus.press_cnt), 32'd0);
        cmp("rst key_down",  32'(bus.key_down),  32'd0);
        cmp("rst err",       32'(bus.err),       32'd0);
        resetn = 1'b1;
        idle(1);

        // Press / release A
        send(8'h1C);
        cmp("A make valid", 32'(bus.evt_valid), 32'd1);
        cmp("A make code",  32'(bus.evt_code),  32'h1C);
        cmp("A ascii",      32'(bus.evt_ascii), 32'h41);
        cmp("A release",    32'(bus.evt_release), 32'd0);
        cmp("A cnt",        32'(bus.press_cnt), 32'd1);
        cmp("A key_down",   32'(bus.key_down),  32'd1);
        send(8'hF0);
        cmp("F0 no evt",    32'(bus.evt_valid), 32'd0);
        send(8'h1C);
        cmp("A break rel",  32'(bus.evt_release), 32'd1);
        cmp("A break kd",   32'(bus.key_down),  32'd0);
        idle(2);

        // Typematic, back-to-back
        send(8'h1C); cmp("typ rep0", 32'(bus.evt_repeat), 32'd0);
        send(8'h1C); cmp("typ rep1", 32'(bus.evt_repeat), 32'd1);
        send(8'h1C); cmp("typ rep2", 32'(bus.evt_repeat), 32'd1);
        cmp("typ cnt", 32'(bus.press_cnt), 32'd2);
        send(8'hF0);
        send(8'h1C); cmp("typ break kd", 32'(bus.key_down), 32'd0);
        idle(1);

        // Extended key
        send(8'hE0);
        cmp("E0 no evt", 32'(bus.evt_valid), 32'd0);
        cmp("E0 no err", 32'(bus.err), 32'd0);
        send(8'h75);
        cmp("ext make ext",   32'(bus.evt_ext),   32'd1);
        cmp("ext make ascii", 32'(bus.evt_ascii), 32'd0);
        cmp("ext held_ext",   32'(bus.held_ext),  32'd1);
        send(8'hE0); send(8'hF0);
        send(8'h75);
        cmp("ext brk rel", 32'(bus.evt_release), 32'd1);
        cmp("ext brk kd",  32'(bus.key_down), 32'd0);
        idle(1);

        // Errors
        send(8'hF0);
        send(8'hE0); cmp("F0E0 err", 32'(bus.err), 32'd1);
        send(8'h74);
        cmp("74 ext",  32'(bus.evt_ext), 32'd1);
        cmp("74 code", 32'(bus.evt_code), 32'h74);
        idle(1);
        send(8'hFF);
        cmp("FF err",  32'(bus.err), 32'd1);
        cmp("FF noev", 32'(bus.evt_valid), 32'd0);
        send(8'hE0);
        // Reset wins over a byte strobed in the same cycle and drops the E0 prefix
        resetn = 1'b0;
        bus.code = 8'h1C;
        @(negedge clk);
        cmp("mid rst kd",  32'(bus.key_down), 32'd0);
        cmp("mid rst cnt", 32'(bus.press_cnt), 32'd0);
        resetn = 1'b1;
        send(8'h1C);
        cmp("post rst ext", 32'(bus.evt_ext), 32'd0);
        cmp("post rst cnt", 32'(bus.press_cnt), 32'd1);
        // Break of a key that is not held: reported, held key kept
        send(8'hF0); send(8'h1D);
        cmp("nomatch rel", 32'(bus.evt_release), 32'd1);
        cmp("nomatch kd",  32'(bus.key_down), 32'd1);
        send(8'hF0); send(8'h1C);
        idle(1);

        // Counter wrap: 256 distinct keys, every byte back-to-back
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 256; i++) begin
            byte unsigned c;
            c = 8'(1 + (i % 128));
            if (i >= 128) send(8'hE0);
            send(c);
            if (i == 254) cmp("wrap cnt 255", 32'(bus.press_cnt), 32'd255);
            if (i >= 128) send(8'hE0);
            send(8'hF0);
            send(c);
        end
        cmp("wrap cnt 0", 32'(bus.press_cnt), 32'd0);
        cmp("wrap kd",    32'(bus.key_down),  32'd0);
        idle(2);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
